ex_stage: RTL and testbench

Execute stage of the 16-bit pipelined processor, between the ID/EX register and the MEM stage. Resolves operand forwarding, runs the single-cycle ALU and a 16-cycle iterative shift-add multiplier, and owns the EX/MEM pipeline register that feeds MEM. While a multiply is in flight it asserts `ex_busy_o` so upstream stages hold, and it inserts bubbles into EX/MEM.

---
 rtl/ex_stage.sv | 151 +++++++++++++++
 tb/tb_ex_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
//   Selects forwarded operands, computes single-cycle ALU results, runs a
//   16-step shift-add multiplier, and owns the EX/MEM pipeline register.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   *E_i                   ID/EX fields and controls of the instruction in EX
//   ForwardAE_i/BE_i       operand source select (01 WB result, 10 MEM ALU out)
//   alu_outM_fwd_i         forwarded MEM-stage ALU value
//   ResultW_i              forwarded WB-stage result
//   stall_EX_MEM_i         hold EX/MEM and multiplier state
//   flush_EX_MEM_i         bubble EX/MEM and abort any multiply
//   ex_busy_o              multiplier busy; upstream must hold
//   *M_o                   EX/MEM register outputs
module ex_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 4,
    parameter int OP_WIDTH   = 4,
    parameter int IMM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] rd1E_i,
    input  logic [DATA_WIDTH-1:0] rd2E_i,
    input  logic [IMM_WIDTH-1:0]  imm8E_i,
    input  logic [REG_WIDTH-1:0]  rsE_i,
    input  logic [REG_WIDTH-1:0]  WriteRegE_i,
    input  logic [OP_WIDTH-1:0]   AluOpE_i,
    input  logic                  AluSrcE_i,
    input  logic                  RegWriteE_i,
    input  logic                  BranchE_i,
    input  logic                  MemReadE_i,
    input  logic                  MemWriteE_i,
    input  logic                  MemToRegE_i,
    input  logic                  MovE_i,
    input  logic [1:0]            ForwardAE_i,
    input  logic [1:0]            ForwardBE_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_fwd_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic                  stall_EX_MEM_i,
    input  logic                  flush_EX_MEM_i,
    output logic                  ex_busy_o,
    output logic [ADDR_WIDTH-1:0] PCM_o,
    output logic [DATA_WIDTH-1:0] alu_outM_o,
    output logic [DATA_WIDTH-1:0] WriteDataM_o,
    output logic [IMM_WIDTH-1:0]  imm8M_o,
    output logic [REG_WIDTH-1:0]  rsM_o,
    output logic [REG_WIDTH-1:0]  WriteRegM_o,
    output logic                  RegWriteM_o,
    output logic                  BranchM_o,
    output logic                  MemReadM_o,
    output logic                  MemWriteM_o,
    output logic                  MemToRegM_o,
    output logic                  MovM_o
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(9);

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] a_reg, b_reg, acc;
    logic [DATA_WIDTH-1:0] a, b_fwd, b, imm_ext, alu_res, pp;
    logic [3:0]            shamt;
    logic                  is_mul;

    assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm8E_i[IMM_WIDTH-1]}}, imm8E_i};

    always_comb begin
        a     = ForwardAE_i == 2'b01 ? ResultW_i : ForwardAE_i == 2'b10 ? alu_outM_fwd_i : rd1E_i;
        b_fwd = ForwardBE_i == 2'b01 ? ResultW_i : ForwardBE_i == 2'b10 ? alu_outM_fwd_i : rd2E_i;
        b     = AluSrcE_i ? imm_ext : b_fwd;
        shamt = b[3:0];
    end

    always_comb begin
        alu_res = '0;
        case (AluOpE_i)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = a ^ b;
            4'd5:    alu_res = a << shamt;
            4'd6:    alu_res = a >> shamt;
            4'd7:    alu_res = DATA_WIDTH'($signed(a) >>> shamt);
            4'd8:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'd10:   alu_res = b;
            default: alu_res = '0;
        endcase
    end

    // One partial product per cycle: bit cnt of B selects A shifted by cnt.
    assign pp        = b_reg[cnt] ? a_reg << cnt : '0;
    assign is_mul    = AluOpE_i == OP_MUL;
    assign ex_busy_o = (state == IDLE && is_mul) || state == MUL;

    always_ff @(posedge clk) begin
        if (rst || flush_EX_MEM_i) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            PCM_o        <= '0;
            alu_outM_o   <= '0;
            WriteDataM_o <= '0;
            imm8M_o      <= '0;
            rsM_o        <= '0;
            WriteRegM_o  <= '0;
            RegWriteM_o  <= 1'b0;
            BranchM_o    <= 1'b0;
            MemReadM_o   <= 1'b0;
            MemWriteM_o  <= 1'b0;
            MemToRegM_o  <= 1'b0;
            MovM_o       <= 1'b0;
            if (rst) begin
                a_reg <= '0;
                b_reg <= '0;
            end
        end else if (!stall_EX_MEM_i) begin
            case (state)
                IDLE: if (is_mul) begin
                    a_reg <= a;
                    b_reg <= b;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    acc   <= acc + pp;
                    cnt   <= cnt + 4'd1;
                    state <= cnt == 4'd15 ? DONE : MUL;
                end
                default: state <= IDLE;
            endcase
            // Busy cycles push bubbles; otherwise capture the EX instruction.
            PCM_o        <= ex_busy_o ? '0 : PCE_i;
            alu_outM_o   <= ex_busy_o ? '0 : state == DONE ? acc : alu_res;
            WriteDataM_o <= ex_busy_o ? '0 : b_fwd;
            imm8M_o      <= ex_busy_o ? '0 : imm8E_i;
            rsM_o        <= ex_busy_o ? '0 : rsE_i;
            WriteRegM_o  <= ex_busy_o ? '0 : WriteRegE_i;
            RegWriteM_o  <= !ex_busy_o && RegWriteE_i;
            BranchM_o    <= !ex_busy_o && BranchE_i;
            MemReadM_o   <= !ex_busy_o && MemReadE_i;
            MemWriteM_o  <= !ex_busy_o && MemWriteE_i;
            MemToRegM_o  <= !ex_busy_o && MemToRegE_i;
            MovM_o       <= !ex_busy_o && MovE_i;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  PCE_i;
    logic [15:0] rd1E_i, rd2E_i;
    logic [7:0]  imm8E_i;
    logic [3:0]  rsE_i, WriteRegE_i, AluOpE_i;
    logic        AluSrcE_i, RegWriteE_i, BranchE_i, MemReadE_i, MemWriteE_i, MemToRegE_i, MovE_i;
    logic [1:0]  ForwardAE_i, ForwardBE_i;
    logic [15:0] alu_outM_fwd_i, ResultW_i;
    logic        stall_EX_MEM_i, flush_EX_MEM_i;
    logic        ex_busy_o;
    logic [7:0]  PCM_o;
    logic [15:0] alu_outM_o, WriteDataM_o;
    logic [7:0]  imm8M_o;
    logic [3:0]  rsM_o, WriteRegM_o;
    logic        RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o;

    int compared = 0;
    int mismatched = 0;
    int n;

    ex_stage dut (
        .clk(clk), .rst(rst), .PCE_i(PCE_i), .rd1E_i(rd1E_i), .rd2E_i(rd2E_i),
        .imm8E_i(imm8E_i), .rsE_i(rsE_i), .WriteRegE_i(WriteRegE_i), .AluOpE_i(AluOpE_i),
        .AluSrcE_i(AluSrcE_i), .RegWriteE_i(RegWriteE_i), .BranchE_i(BranchE_i),
        .MemReadE_i(MemReadE_i), .MemWriteE_i(MemWriteE_i), .MemToRegE_i(MemToRegE_i),
        .MovE_i(MovE_i), .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i),
        .alu_outM_fwd_i(alu_outM_fwd_i), .ResultW_i(ResultW_i),
        .stall_EX_MEM_i(stall_EX_MEM_i), .flush_EX_MEM_i(flush_EX_MEM_i),
        .ex_busy_o(ex_busy_o), .PCM_o(PCM_o), .alu_outM_o(alu_outM_o),
        .WriteDataM_o(WriteDataM_o), .imm8M_o(imm8M_o), .rsM_o(rsM_o),
        .WriteRegM_o(WriteRegM_o), .RegWriteM_o(RegWriteM_o), .BranchM_o(BranchM_o),
        .MemReadM_o(MemReadM_o), .MemWriteM_o(MemWriteM_o), .MemToRegM_o(MemToRegM_o),
        .MovM_o(MovM_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ctrls();
        return {RegWriteM_o, BranchM_o, MemReadM_o, MemWriteM_o, MemToRegM_o, MovM_o};
    endfunction

    task automatic op(input logic [3:0] o, input logic [15:0] r1, input logic [15:0] r2);
        AluOpE_i = o;
        rd1E_i   = r1;
        rd2E_i   = r2;
        #1;
    endtask

    initial begin
        rst = 1'b1; PCE_i = 8'h5A; rd1E_i = 16'h1111; rd2E_i = 16'h2222; imm8E_i = 8'h33;
        rsE_i = 4'd2; WriteRegE_i = 4'd3; AluOpE_i = 4'd0; AluSrcE_i = 1'b0;
        RegWriteE_i = 1'b1; BranchE_i = 1'b1; MemReadE_i = 1'b1; MemWriteE_i = 1'b1;
        MemToRegE_i = 1'b1; MovE_i = 1'b1; ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
        alu_outM_fwd_i = 16'h0; ResultW_i = 16'h0; stall_EX_MEM_i = 1'b0; flush_EX_MEM_i = 1'b0;
        tick; tick;
        chk("rst_ctrls", 32'(ctrls()), 32'h0);
        chk("rst_alu", 32'(alu_outM_o), 32'h0);
        chk("rst_pc", 32'(PCM_o), 32'h0);
        chk("rst_busy", 32'(ex_busy_o), 32'h0);
        rst = 1'b0; BranchE_i = 1'b0; MemReadE_i = 1'b0; MemWriteE_i = 1'b0; MovE_i = 1'b0;
        MemToRegE_i = 1'b0; PCE_i = 8'h12;
        op(4'd0, 16'h7FFF, 16'h0001);
        tick;
        chk("add_res", 32'(alu_outM_o), 32'h8000);
        chk("add_ctrls", 32'(ctrls()), 32'h20);
        chk("add_pc", 32'(PCM_o), 32'h12);
        chk("add_wreg", 32'(WriteRegM_o), 32'h3);
        chk("add_wdata", 32'(WriteDataM_o), 32'h0001);
        chk("add_imm", 32'(imm8M_o), 32'h33);
        ForwardAE_i = 2'b10; alu_outM_fwd_i = 16'h0005; ForwardBE_i = 2'b01; ResultW_i = 16'h0003;
        op(4'd1, 16'hAAAA, 16'hAAAA);
        tick;
        chk("sub_fwd", 32'(alu_outM_o), 32'h0002);
        chk("sub_wdata", 32'(WriteDataM_o), 32'h0003);
        ForwardAE_i = 2'b00; ForwardBE_i = 2'b00; AluSrcE_i = 1'b1; imm8E_i = 8'hFF;
        op(4'd0, 16'h0010, 16'h1234);
        tick;
        chk("addi_neg", 32'(alu_outM_o), 32'h000F);
        chk("addi_wdata", 32'(WriteDataM_o), 32'h1234);
        imm8E_i = 8'h04;
        op(4'd7, 16'h8000, 16'h0000);
        tick;
        chk("sra", 32'(alu_outM_o), 32'hF800);
        AluSrcE_i = 1'b0;
        op(4'd8, 16'hFFFF, 16'h0001);
        tick;
        chk("slt", 32'(alu_outM_o), 32'h0001);
        op(4'd13, 16'h1234, 16'h4321);
        tick;
        chk("op13", 32'(alu_outM_o), 32'h0000);

        // MUL with A forwarded; forwarding input changes after latch are ignored.
        PCE_i = 8'h40; WriteRegE_i = 4'd7; MemToRegE_i = 1'b1;
        ForwardAE_i = 2'b10; alu_outM_fwd_i = 16'h0123;
        op(4'd9, 16'h0000, 16'h0045);
        for (int c = 0; c < 17; c++) begin
            chk("mul_busy", 32'(ex_busy_o), 32'h1);
            tick;
            alu_outM_fwd_i = 16'hFFFF;
            chk("mul_bubble", 32'(ctrls()), 32'h0);
        end
        chk("mul_done_busy", 32'(ex_busy_o), 32'h0);
        tick;
        AluOpE_i = 4'd0;
        chk("mul_res", 32'(alu_outM_o), 32'h4E6F);
        chk("mul_ctrls", 32'(ctrls()), 32'h22);
        chk("mul_wreg", 32'(WriteRegM_o), 32'h7);
        chk("mul_pc", 32'(PCM_o), 32'h40);
        chk("mul_wdata", 32'(WriteDataM_o), 32'h0045);

        // MUL with a 3-cycle stall pulse, then a stall while in DONE.
        ForwardAE_i = 2'b00; MemToRegE_i = 1'b0;
        op(4'd9, 16'h0123, 16'h0045);
        n = 0;
        while (ex_busy_o && n < 40) begin
            stall_EX_MEM_i = n >= 6 && n <= 8;
            tick;
            n++;
        end
        stall_EX_MEM_i = 1'b0;
        chk("stall_busy_len", 32'(n), 32'd20);
        chk("stall_bubble", 32'(ctrls()), 32'h0);
        stall_EX_MEM_i = 1'b1;
        tick; tick;
        chk("done_stall_hold", 32'(ctrls()), 32'h0);
        chk("done_stall_busy", 32'(ex_busy_o), 32'h0);
        stall_EX_MEM_i = 1'b0;
        tick;
        AluOpE_i = 4'd0;
        chk("stall_mul_res", 32'(alu_outM_o), 32'h4E6F);
        chk("stall_mul_ctrls", 32'(ctrls()), 32'h20);

        // Flush at cnt=7 aborts the multiply.
        op(4'd9, 16'h0123, 16'h0045);
        for (int c = 0; c < 8; c++) tick;
        chk("pre_flush_busy", 32'(ex_busy_o), 32'h1);
        flush_EX_MEM_i = 1'b1;
        op(4'd0, 16'h0002, 16'h0003);
        tick;
        flush_EX_MEM_i = 1'b0;
        #1;
        chk("flush_busy", 32'(ex_busy_o), 32'h0);
        chk("flush_ctrls", 32'(ctrls()), 32'h0);
        chk("flush_alu", 32'(alu_outM_o), 32'h0);
        tick;
        chk("post_flush_add", 32'(alu_outM_o), 32'h0005);

        // Reset mid-multiply.
        op(4'd9, 16'h0123, 16'h0045);
        for (int c = 0; c < 5; c++) tick;
        rst = 1'b1;
        op(4'd0, 16'h0004, 16'h0005);
        tick;
        rst = 1'b0;
        #1;
        chk("rstm_busy", 32'(ex_busy_o), 32'h0);
        chk("rstm_ctrls", 32'(ctrls()), 32'h0);
        chk("rstm_alu", 32'(alu_outM_o), 32'h0);
        chk("rstm_wdata", 32'(WriteDataM_o), 32'h0);
        tick;
        chk("post_rst_add", 32'(alu_outM_o), 32'h0009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
